// File: rtl/ifu_fetch.sv
// ifu_fetch: fetches the instruction at pc_i over a req/gnt/rvalid bus into a one-entry valid/ready buffer.
// Ports: clk, rst_n (async active-low); pc_i, jump_flag_i, hold_req_o to/from the PC register;
//   ibus_req_o/ibus_addr_o/ibus_gnt_i/ibus_rvalid_i/ibus_rdata_i instruction bus;
//   inst_valid_o/inst_o/inst_addr_o/inst_fault_o/inst_ready_i decode-side buffer.
// Optional: IFU_MISALIGN_CHK_EN turns misaligned PCs into a fault entry instead of a bus fetch.
module ifu_fetch #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int ALIGN_LSB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_i,
  input  logic          jump_flag_i,
  output logic          hold_req_o,
  output logic          ibus_req_o,
  output logic [AW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_fault_o,
  input  logic          inst_ready_i
);
  typedef enum logic {REQ, WAIT} state_t;
`ifdef IFU_MISALIGN_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  state_t state, state_d;
  logic kill, kill_d;
  logic [AW-1:0] addr_q;
  logic space, mis, fault_ld, rsp_ld, load, pop;
  // A request is only issued when the buffer is empty or draining, so the response always fits.
  assign space = !inst_valid_o | inst_ready_i;
  assign mis = CHK & (pc_i[ALIGN_LSB-1:0] != '0);
  assign ibus_req_o = (state == REQ) & space & !jump_flag_i & !mis;
  assign ibus_addr_o = pc_i;
  assign hold_req_o = !(ibus_req_o & ibus_gnt_i) & !jump_flag_i;
  assign fault_ld = (state == REQ) & space & !jump_flag_i & mis;
  assign rsp_ld = (state == WAIT) & ibus_rvalid_i & !kill & !jump_flag_i;
  assign load = rsp_ld | fault_ld;
  assign pop = inst_valid_o & inst_ready_i;
  // kill marks the outstanding response as belonging to a flushed path.
  always_comb begin
    state_d = state;
    kill_d = kill;
    if (state == REQ) state_d = (ibus_req_o & ibus_gnt_i) ? WAIT : REQ;
    else begin
      state_d = ibus_rvalid_i ? REQ : WAIT;
      kill_d = ibus_rvalid_i ? 1'b0 : (kill | jump_flag_i);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= REQ;
      kill <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_d;
      kill <= kill_d;
      if (ibus_req_o & ibus_gnt_i) addr_q <= pc_i;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inst_valid_o <= 1'b0;
      inst_o <= '0;
      inst_addr_o <= '0;
    end else if (jump_flag_i) inst_valid_o <= 1'b0;
    else if (load) begin
      inst_valid_o <= 1'b1;
      inst_o <= fault_ld ? '0 : ibus_rdata_i;
      inst_addr_o <= fault_ld ? pc_i : addr_q;
    end else if (pop) inst_valid_o <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inst_fault_o <= 1'b0;
    else if (jump_flag_i) inst_fault_o <= 1'b0;
    else if (load) inst_fault_o <= fault_ld;
    else if (pop) inst_fault_o <= 1'b0;
`else
  assign inst_fault_o = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed cycle-by-cycle vectors plus an async-reset sequence for ifu_fetch.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic jump_flag_i = 1'b0;
  logic hold_req_o, ibus_req_o, ibus_gnt_i, ibus_rvalid_i, inst_valid_o, inst_fault_o, inst_ready_i;
  logic [31:0] ibus_addr_o, ibus_rdata_i, inst_o, inst_addr_o;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .hold_req_o(hold_req_o),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_fault_o(inst_fault_o), .inst_ready_i(inst_ready_i)
  );
  typedef struct {
    logic [31:0] pc;
    logic j, g, rv;
    logic [31:0] rd;
    logic rdy;
    logic req, hold, v;
    logic [31:0] inst, addr;
  } vec_t;
  vec_t tbl[26];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] pc, input logic j, g, rv, input logic [31:0] rd,
                              input logic rdy, req, hold, v, input logic [31:0] inst, addr);
    mk = '{pc, j, g, rv, rd, rdy, req, hold, v, inst, addr};
  endfunction
  initial begin
    //               pc     j  g  rv rdata          rdy req hold v inst          addr
    tbl[0]  = mk(32'h000, 0, 1, 0, 32'h0,          1,  1,  0,  0, 32'h0,        32'h0);
    tbl[1]  = mk(32'h004, 0, 1, 1, 32'h00000013,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[2]  = mk(32'h004, 0, 1, 0, 32'h0,          1,  1,  0,  1, 32'h00000013, 32'h0);
    tbl[3]  = mk(32'h008, 0, 1, 1, 32'h00100093,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[4]  = mk(32'h008, 0, 1, 0, 32'h0,          1,  1,  0,  1, 32'h00100093, 32'h4);
    tbl[5]  = mk(32'h00c, 0, 1, 1, 32'h00200113,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[6]  = mk(32'h00c, 0, 1, 0, 32'h0,          0,  0,  1,  1, 32'h00200113, 32'h8);
    tbl[7]  = mk(32'h00c, 0, 1, 0, 32'h0,          0,  0,  1,  1, 32'h00200113, 32'h8);
    tbl[8]  = mk(32'h00c, 0, 1, 0, 32'h0,          1,  1,  0,  1, 32'h00200113, 32'h8);
    tbl[9]  = mk(32'h010, 0, 1, 1, 32'h00300193,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[10] = mk(32'h010, 0, 1, 0, 32'h0,          1,  1,  0,  1, 32'h00300193, 32'hc);
    tbl[11] = mk(32'h014, 1, 1, 0, 32'h0,          1,  0,  0,  0, 32'h0,        32'h0);
    tbl[12] = mk(32'h100, 0, 1, 1, 32'hdeadbeef,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[13] = mk(32'h100, 0, 1, 0, 32'h0,          1,  1,  0,  0, 32'h0,        32'h0);
    tbl[14] = mk(32'h104, 0, 1, 1, 32'h00400213,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[15] = mk(32'h104, 0, 1, 0, 32'h0,          0,  0,  1,  1, 32'h00400213, 32'h100);
    tbl[16] = mk(32'h104, 1, 1, 0, 32'h0,          0,  0,  0,  1, 32'h00400213, 32'h100);
    tbl[17] = mk(32'h200, 0, 1, 1, 32'hbadbad00,   0,  1,  0,  0, 32'h0,        32'h0);
    tbl[18] = mk(32'h204, 1, 1, 1, 32'hbeefbeef,   1,  0,  0,  0, 32'h0,        32'h0);
    tbl[19] = mk(32'h300, 0, 0, 0, 32'h0,          1,  1,  1,  0, 32'h0,        32'h0);
    tbl[20] = mk(32'h300, 0, 1, 0, 32'h0,          1,  1,  0,  0, 32'h0,        32'h0);
    tbl[21] = mk(32'h304, 0, 1, 1, 32'h00500293,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[22] = mk(32'h304, 0, 0, 0, 32'h0,          1,  1,  1,  1, 32'h00500293, 32'h300);
    tbl[23] = mk(32'h302, 0, 1, 0, 32'h0,          1,  1,  0,  0, 32'h0,        32'h0);
    tbl[24] = mk(32'h306, 0, 1, 1, 32'h00000011,   1,  0,  1,  0, 32'h0,        32'h0);
    tbl[25] = mk(32'h306, 0, 0, 0, 32'h0,          0,  0,  1,  1, 32'h00000011, 32'h302);
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = '0; inst_ready_i = 1;
    #2;
    chk("rst_valid", -1, {31'b0, inst_valid_o}, 32'h0);
    chk("rst_inst", -1, inst_o, 32'h0);
    chk("rst_addr", -1, inst_addr_o, 32'h0);
    chk("rst_fault", -1, {31'b0, inst_fault_o}, 32'h0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 26; i++) begin
      pc_i = tbl[i].pc; jump_flag_i = tbl[i].j; ibus_gnt_i = tbl[i].g; ibus_rvalid_i = tbl[i].rv;
      ibus_rdata_i = tbl[i].rd; inst_ready_i = tbl[i].rdy;
      @(negedge clk);
      chk("req", i, {31'b0, ibus_req_o}, {31'b0, tbl[i].req});
      chk("hold", i, {31'b0, hold_req_o}, {31'b0, tbl[i].hold});
      chk("addr_out", i, ibus_addr_o, tbl[i].pc);
      chk("valid", i, {31'b0, inst_valid_o}, {31'b0, tbl[i].v});
      chk("fault", i, {31'b0, inst_fault_o}, 32'h0);
      if (tbl[i].v) begin
        chk("inst", i, inst_o, tbl[i].inst);
        chk("inst_addr", i, inst_addr_o, tbl[i].addr);
      end
      @(posedge clk); #1;
    end
    // Async reset while a fetch at 0x400 is outstanding.
    pc_i = 32'h400; jump_flag_i = 0; ibus_gnt_i = 1; ibus_rvalid_i = 0; inst_ready_i = 1;
    @(posedge clk); #1;
    chk("wait_req", 100, {31'b0, ibus_req_o}, 32'h0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 101, {31'b0, inst_valid_o}, 32'h0);
    chk("arst_inst", 101, inst_o, 32'h0);
    chk("arst_addr", 101, inst_addr_o, 32'h0);
    chk("arst_req", 101, {31'b0, ibus_req_o}, 32'h1);
    @(negedge clk); rst_n = 1; ibus_gnt_i = 0; ibus_rvalid_i = 1; ibus_rdata_i = 32'hbad0bad0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stale_valid", 102, {31'b0, inst_valid_o}, 32'h0);
    chk("stale_req", 102, {31'b0, ibus_req_o}, 32'h1);
    ibus_gnt_i = 1; ibus_rvalid_i = 0;
    @(posedge clk); #1 ibus_gnt_i = 0; ibus_rvalid_i = 1; ibus_rdata_i = 32'h00000077; pc_i = 32'h404;
    @(posedge clk); #1 ibus_rvalid_i = 0; inst_ready_i = 0;
    @(negedge clk);
    chk("post_valid", 103, {31'b0, inst_valid_o}, 32'h1);
    chk("post_inst", 103, inst_o, 32'h77);
    chk("post_addr", 103, inst_addr_o, 32'h400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Consumer end of the PC register's interface: takes the current PC, fetches the instruction word from instruction memory over a req/gnt/rvalid bus, and presents it to decode through a valid/ready output buffer.
- Drives the PC register's hold input so the PC advances only when a fetch is granted.
- Drops the hold on a jump so the PC loads the target; hold has priority over jump in the PC register.
- One outstanding bus transaction, one-entry output buffer.

Parameters:
- AW, 32, address width of pc_i / ibus_addr_o / inst_addr_o
- DW, 32, instruction/data width
- ALIGN_LSB, 2, number of PC LSBs that must be zero for an aligned fetch

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- pc_i  input  AW  current PC from the PC register
- jump_flag_i  input  1  jump/flush from execute (same signal that loads the PC register)
- hold_req_o  output  1  to the PC register hold input; 1 = keep PC
- ibus_req_o  output  1  fetch request
- ibus_addr_o  output  AW  fetch address (= pc_i)
- ibus_gnt_i  input  1  request accepted this cycle
- ibus_rvalid_i  input  1  read data valid
- ibus_rdata_i  input  DW  read data
- inst_valid_o  output  1  output buffer holds an instruction
- inst_o  output  DW  instruction
- inst_addr_o  output  AW  address of inst_o
- inst_fault_o  output  1  misaligned fetch fault, valid with inst_valid_o
- inst_ready_i  input  1  decode accepts; pop = inst_valid_o & inst_ready_i

Behaviour:
- Reset (async): state=REQ, kill=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, inst_fault_o=0, addr_q=0.
- After reset, ibus_rvalid_i is ignored while in REQ.
- FSM states: REQ, WAIT.
- space = !inst_valid_o | inst_ready_i.
- ibus_req_o = (state==REQ) & space & !jump_flag_i. Combinational. Request may drop without grant; no req stability is required.
- ibus_addr_o = pc_i.
- hold_req_o = !(ibus_req_o & ibus_gnt_i) & !jump_flag_i. The PC advances by 4 in the cycle after a grant and loads the target on a jump.
- REQ state: on ibus_req_o & ibus_gnt_i, addr_q <= pc_i and go to WAIT. Otherwise stay.
- WAIT state, no jump: on ibus_rvalid_i with kill=0, load the buffer and go to REQ.
  - Buffer load: inst_o <= ibus_rdata_i, inst_addr_o <= addr_q, inst_valid_o <= 1.
- WAIT state, jump_flag_i=1 without rvalid: kill <= 1, stay in WAIT.
- WAIT state, rvalid with kill=1, or rvalid and jump in the same cycle: discard data, kill <= 0, go to REQ.
- Buffer pop: inst_valid_o <= 0 unless reloaded in the same cycle. Load and pop in the same cycle leaves valid=1 with the new data.
- jump_flag_i clears inst_valid_o in that cycle, with priority over load.
- Capacity rule: a request is issued only when the buffer will have space, so a response always fits. No response is ever dropped except by kill.
- Latency (zero-wait bus, gnt same cycle, rvalid next cycle):
  - cycle N: req/gnt
  - cycle N+1: rvalid
  - cycle N+2: inst_valid_o=1
  - Sustained throughput: 1 instruction per 2 cycles.
- Jump during REQ: no request that cycle; the next cycle requests the target pc_i.
- gnt while ibus_req_o=0 is ignored. rvalid in REQ is ignored.

Optional Feature:
- Macro IFU_MISALIGN_CHK_EN.
- Defined: in REQ with space, !jump_flag_i and pc_i[ALIGN_LSB-1:0]!=0:
  - no bus request is issued;
  - the buffer loads inst_o=0, inst_addr_o=pc_i, inst_fault_o=1, inst_valid_o=1;
  - hold_req_o=1, so the PC stays until a jump redirects it;
  - inst_fault_o clears on pop or jump.
- Not defined: inst_fault_o is tied to 0 and misaligned PCs are fetched normally.

Test Plan:
- Reset release, pc_i=0x0, gnt=1 on req, rvalid next cycle with rdata=0x00000013, ready=1 -> hold_req_o=0 in grant cycle; inst_valid_o=1, inst_o=0x13, inst_addr_o=0x0 two cycles after grant.
- Stream pc 0x0,0x4,0x8, ready=1 -> inst_addr_o sequence 0x0,0x4,0x8, one instruction every 2 cycles, no gaps or duplicates.
- ready=0 with buffer full -> ibus_req_o=0 and hold_req_o=1, pc_i stable; raise ready -> request resumes the same cycle.
- Jump asserted in WAIT (addr 0x8 outstanding), target 0x100 -> 0x8 response discarded, next grant at 0x100, inst_addr_o=0x100.
- Jump coinciding with rvalid and a full buffer -> buffer invalidated, response discarded, inst_valid_o=0 next cycle.
- rst_n pulsed low while in WAIT -> all outputs return to reset values asynchronously; the stale rvalid after release is ignored.
